// File: rtl/vbs_sync_decoder.sv
// vbs_sync_decoder: recovers column/line position, sync strobes and lock state
// from a 1-bit composite sync stream, with the pixel sample registered alongside.
module vbs_sync_decoder #(
    parameter int SHORT_MIN = 12,
    parameter int SHORT_MAX = 16,
    parameter int VSYNC_MIN = 250,
    parameter int LINES     = 313
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync,
    input  logic       pixel,
    output logic [7:0] col,
    output logic [8:0] line,
    output logic       hsync_pulse,
    output logic       vsync_pulse,
    output logic       locked,
    output logic       pixel_out
);
    typedef enum logic [1:0] {HUNT, SYNCING, LOCKED} state_t;

    state_t     state, state_nx;
    logic       sync_q, hcnt, hcnt_nx;
    logic [8:0] low_run;
    logic       rise, hs_ev, vs_ev, expected, missing, at_vs_pos, in_active;
    logic [7:0] col_fr, col_nx;
    logic [8:0] line_fr, line_nx;

    assign rise    = sync && !sync_q;
    assign hs_ev   = rise && low_run >= 9'(SHORT_MIN) && low_run <= 9'(SHORT_MAX);
    assign vs_ev   = rise && low_run >= 9'(VSYNC_MIN);
    assign col_fr  = col + 8'd1;
    assign line_fr = (col != 8'd255) ? line : (line == 9'(LINES - 1)) ? 9'd0 : line + 9'd1;
    // line never exceeds LINES-1, so only the lower bound of the active range needs testing
    assign in_active = line >= 9'd4;
    assign expected  = col_fr == 8'd15 && in_active;
    // hsync_pulse is high exactly when the previous sample was an accepted hsync at col 15
    assign missing   = col_fr == 8'd16 && in_active && !hsync_pulse;
    assign at_vs_pos = col_fr == 8'd1 && line_fr == 9'd1;
    assign col_nx    = vs_ev ? 8'd1 : hs_ev ? 8'd15 : col_fr;
    assign line_nx   = vs_ev ? 9'd1 : hs_ev ? line : line_fr;
    assign locked    = state == LOCKED;

    always_comb begin
        state_nx = state;
        hcnt_nx  = hcnt;
        if (vs_ev) begin
            state_nx = (state == LOCKED && at_vs_pos) ? LOCKED : SYNCING;
            hcnt_nx  = 1'b0;
        end else if (hs_ev && !expected) begin
            state_nx = HUNT;
        end else if (hs_ev && state == SYNCING) begin
            hcnt_nx  = 1'b1;
            state_nx = hcnt ? LOCKED : SYNCING;
        end else if (missing && state == LOCKED) begin
            state_nx = HUNT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            hcnt        <= 1'b0;
            sync_q      <= 1'b1;
            low_run     <= 9'd0;
            col         <= 8'd0;
            line        <= 9'd0;
            hsync_pulse <= 1'b0;
            vsync_pulse <= 1'b0;
            pixel_out   <= 1'b0;
        end else begin
            state       <= state_nx;
            hcnt        <= hcnt_nx;
            sync_q      <= sync;
            low_run     <= sync ? 9'd0 : (low_run == 9'd511) ? low_run : low_run + 9'd1;
            col         <= col_nx;
            line        <= line_nx;
            hsync_pulse <= hs_ev;
            vsync_pulse <= vs_ev;
            pixel_out   <= pixel;
        end
    end
endmodule

// File: tb/tb_vbs_sync_decoder.sv
// tb_vbs_sync_decoder: drives a scaled-down composite sync stream with faults injected
// and scoreboards every output sample against a position/lock reference model.
module tb_vbs_sync_decoder;
    localparam int LN    = 24;
    localparam int FRAME = 256 * LN;

    logic       clk = 1'b0, reset = 1'b1, sync = 1'b1, pixel = 1'b0;
    logic [7:0] col;
    logic [8:0] line;
    logic       hsync_pulse, vsync_pulse, locked, pixel_out;

    typedef struct packed {
        logic [7:0] col;
        logic [8:0] line;
        logic       hs;
        logic       vs;
        logic       lk;
        logic       px;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0, errors = 0;

    vbs_sync_decoder #(.LINES(LN)) dut (
        .clk(clk), .reset(reset), .sync(sync), .pixel(pixel),
        .col(col), .line(line), .hsync_pulse(hsync_pulse), .vsync_pulse(vsync_pulse),
        .locked(locked), .pixel_out(pixel_out)
    );

    always #5 clk = ~clk;

    // Reference: absolute frame position plus a sample history from which run lengths are measured
    int mpos = 0, mstate = 0, mgood = 0;
    bit prev_h = 1'b0;
    bit hist[$];

    task automatic model(input logic s, input logic p, input logic r);
        exp_t e;
        int   run, pred, npos;
        bit   rise, hs, vs, expct, miss;
        e = '0;
        if (r) begin
            mpos = 0; mstate = 0; mgood = 0; prev_h = 1'b0;
            hist.delete();
        end else begin
            run = 0;
            for (int i = hist.size() - 1; i >= 0 && hist[i] == 1'b0; i--) run++;
            if (run > 511) run = 511;
            rise  = s && hist.size() > 0 && hist[hist.size() - 1] == 1'b0;
            hs    = rise && run >= 12 && run <= 16;
            vs    = rise && run >= 250;
            pred  = (mpos + 1) % FRAME;
            expct = (pred % 256 == 15) && (mpos / 256 >= 4);
            miss  = mstate == 2 && pred % 256 == 16 && pred / 256 >= 4 && !prev_h;
            npos  = vs ? 257 : hs ? (mpos / 256) * 256 + 15 : pred;
            if (vs) begin
                mstate = (mstate == 2 && pred == 257) ? 2 : 1;
                mgood  = 0;
            end else if (hs) begin
                if (!expct) mstate = 0;
                else if (mstate == 1) begin
                    mgood++;
                    if (mgood == 2) mstate = 2;
                end
            end else if (miss) mstate = 0;
            prev_h = hs;
            mpos   = npos;
            hist.push_back(s);
            if (hist.size() > 600) void'(hist.pop_front());
            e.col  = 8'(npos % 256);
            e.line = 9'(npos / 256);
            e.hs   = hs;
            e.vs   = vs;
            e.lk   = mstate == 2;
            e.px   = p;
        end
        sbq.push_back(e);
    endtask

    function automatic logic ideal(input int l, input int c);
        if (l == 0 || (l == 1 && c == 0)) return 1'b0;
        if (l == 1 || l == 2) return !(c >= 10 && c <= 251);
        if (l >= 4) return !(c >= 1 && c <= 14);
        return 1'b1;
    endfunction

    function automatic logic sweep(input int l, input int c, input logic s);
        int lens[6]  = '{11, 12, 16, 17, 249, 250};
        int lnums[6] = '{6, 8, 10, 12, 14, 18};
        int st;
        for (int k = 0; k < 6; k++) begin
            st = (k < 4) ? 30 : 1;
            if (l == lnums[k] && c >= st && c < st + lens[k]) return 1'b0;
        end
        return s;
    endfunction

    task automatic drive(input logic s, input logic p, input logic r);
        @(negedge clk);
        sync  = s;
        pixel = p;
        if (r && !reset) begin
            reset = 1'b1;
            #1;
            checks++;
            if ({col, line, hsync_pulse, vsync_pulse, locked, pixel_out} != 22'd0) begin
                errors++;
                $display("FAIL async_reset got col=%0d line=%0d hs=%b vs=%b lk=%b px=%b want all 0",
                         col, line, hsync_pulse, vsync_pulse, locked, pixel_out);
            end
        end
        reset = r;
        model(s, p, r);
    endtask

    initial begin
        int   rlen, rcol;
        logic s;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1);
        for (int f = 0; f < 11; f++) begin
            for (int l = 0; l < LN; l++) begin
                rlen = 0;
                rcol = 0;
                if (f == 8 && l >= 6 && $urandom_range(0, 3) == 0) begin
                    rlen = $urandom_range(8, 20);
                    rcol = $urandom_range(30, 200);
                end
                for (int c = 0; c < 256; c++) begin
                    s = ideal(l, c);
                    if (f == 3 && l == 10 && c >= 1 && c <= 14) s = 1'b1;
                    if (f == 5 && l == 8 && c >= 86 && c <= 99) s = 1'b0;
                    if (f == 7) s = sweep(l, c, s);
                    if (rlen > 0 && c >= rcol && c < rcol + rlen) s = 1'b0;
                    drive(s, 1'($urandom_range(0, 1)), f == 9 && l == 12 && c >= 50 && c < 53);
                end
            end
        end
        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        exp_t e, g;
        int   cyc = 0, vs_cyc = -100000;
        logic lk_q = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            g = {col, line, hsync_pulse, vsync_pulse, locked, pixel_out};
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL sample cyc %0d got col=%0d line=%0d hs=%b vs=%b lk=%b px=%b want col=%0d line=%0d hs=%b vs=%b lk=%b px=%b",
                             cyc, g.col, g.line, g.hs, g.vs, g.lk, g.px, e.col, e.line, e.hs, e.vs, e.lk, e.px);
                end
            end
            if (vsync_pulse) vs_cyc = cyc;
            if (locked && !lk_q) begin
                checks++;
                if (cyc - vs_cyc != 1038) begin
                    errors++;
                    $display("FAIL lock_latency got %0d want 1038", cyc - vs_cyc);
                end
            end
            lk_q = locked;
        end
    end
endmodule
